// File: rtl/multicycle_control_pkg.sv
// Shared opcode, ALU-op, state and instruction-class definitions
// for the multi-cycle sequencer.
package multicycle_control_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_ILL
  } iclass_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode decode: ALU op, operand/writeback
// selects, destination select and instruction class.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_op,
  output logic       alu_src_imm,
  output logic       wd_sel,
  output logic       dest_rd,
  output iclass_t    cls
);

  always_comb begin
    alu_op      = ALU_AND;
    alu_src_imm = 1'b0;
    wd_sel      = 1'b0;
    dest_rd     = 1'b0;
    cls         = C_ILL;
    unique case (1'b1)
      (op == OP_ADD): begin
        alu_op  = ALU_ADD;
        dest_rd = 1'b1;
        cls     = C_R;
      end
      (op == OP_SUB): begin
        alu_op  = ALU_SUB;
        dest_rd = 1'b1;
        cls     = C_R;
      end
      (op == OP_AND): begin
        alu_op  = ALU_AND;
        dest_rd = 1'b1;
        cls     = C_R;
      end
      (op == OP_OR): begin
        alu_op  = ALU_OR;
        dest_rd = 1'b1;
        cls     = C_R;
      end
      (op == OP_SLT): begin
        alu_op  = ALU_SLT;
        dest_rd = 1'b1;
        cls     = C_R;
      end
      (op == OP_ADDI): begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b1;
        cls         = C_I;
      end
      (op == OP_LW): begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b1;
        wd_sel      = 1'b1;
        cls         = C_LOAD;
      end
      (op == OP_SW): begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b1;
        cls         = C_STORE;
      end
      (op == OP_BEQ),
      (op == OP_BNE): begin
        alu_op = ALU_SUB;
        cls    = C_BRANCH;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: latches one instruction and steps the
// register file, ALU and data memory through its phases.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zero,
  input  logic        mem_ack,
  output logic [1:0]  rr1,
  output logic [1:0]  rr2,
  output logic [1:0]  wr,
  output logic        regwrite,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [15:0] imm,
  output logic        wd_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal
);

  state_t      state, state_nx;
  logic [15:0] ir;
  logic [2:0]  dec_alu_op;
  logic        dec_src_imm;
  logic        dec_wd_sel;
  logic        dec_dest_rd;
  iclass_t     cls;
  logic        busy;
  logic [1:0]  dest;

  multicycle_control_decode u_dec (
    .op          (ir[15:12]),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .wd_sel      (dec_wd_sel),
    .dest_rd     (dec_dest_rd),
    .cls         (cls)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && instr_valid)
        ir <= instr;
    end
  end

  assign busy = (state != S_IDLE);
  assign dest = dec_dest_rd ? ir[7:6] : ir[9:8];

  // Datapath selects are held at zero while idle.
  always_comb begin
    rr1         = busy ? ir[11:10] : 2'd0;
    rr2         = busy ? ir[9:8] : 2'd0;
    wr          = busy ? dest : 2'd0;
    alu_op      = busy ? dec_alu_op : 3'd0;
    alu_src_imm = busy & dec_src_imm;
    wd_sel      = busy & dec_wd_sel;
    imm         = busy ? sext8(ir[7:0]) : 16'd0;
  end

  always_comb begin
    state_nx     = state;
    instr_ready  = 1'b0;
    regwrite     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          illegal  = 1'b1;
          done     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          (cls == C_LOAD),
          (cls == C_STORE): state_nx = S_MEM;
          (cls == C_BRANCH): begin
            branch_taken = (ir[15:12] == OP_BNE) ? !zero : zero;
            done         = 1'b1;
            state_nx     = S_IDLE;
          end
          default: state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_STORE);
        if (mem_ack) begin
          if (cls == C_STORE) begin
            done     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        // r0 is hardwired; the cycle still runs to keep timing uniform.
        regwrite = (dest != 2'd0);
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: directed vector table, hand sequences for
// held-valid and mid-MEM reset, then randomized model comparison.
module tb_multicycle_control;

  logic        clock;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero;
  logic        mem_ack;
  logic [1:0]  rr1, rr2, wr;
  logic        regwrite;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic [15:0] imm;
  logic        wd_sel;
  logic        mem_req, mem_we;
  logic        branch_taken, done, illegal;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_control dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .zero         (zero),
    .mem_ack      (mem_ack),
    .rr1          (rr1),
    .rr2          (rr2),
    .wr           (wr),
    .regwrite     (regwrite),
    .alu_op       (alu_op),
    .alu_src_imm  (alu_src_imm),
    .imm          (imm),
    .wd_sel       (wd_sel),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .branch_taken (branch_taken),
    .done         (done),
    .illegal      (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic        z;
    int          dly;
    int          n;
    logic        rw;
    logic [1:0]  wr;
    logic [2:0]  aop;
    logic [15:0] imm;
    logic        src;
    logic        wds;
    logic        ill;
    logic        bt;
    logic        mem;
    logic        we;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  // Reference model: cycle counts and outputs from the ISA rules.
  function automatic vec_t model(input logic [15:0] i,
                                 input logic z, input int dly);
    vec_t v;
    int   op;
    logic [1:0] rt, rd;
    op = int'(i[15:12]);
    rt = i[9:8];
    rd = i[7:6];
    v = '{instr: i, z: z, dly: dly, n: 1, rw: 0, wr: rt,
          aop: 3'b000, imm: {{8{i[7]}}, i[7:0]}, src: 0,
          wds: 0, ill: 0, bt: 0, mem: 0, we: 0};
    if (op <= 4) begin
      v.n = 3;
      v.wr = rd;
      v.rw = (rd != 0);
      case (op)
        0: v.aop = 3'b010;
        1: v.aop = 3'b110;
        2: v.aop = 3'b000;
        3: v.aop = 3'b001;
        default: v.aop = 3'b111;
      endcase
    end else if (op == 5) begin
      v.n = 3; v.rw = (rt != 0); v.aop = 3'b010; v.src = 1;
    end else if (op == 6) begin
      v.n = 3 + dly; v.rw = (rt != 0); v.aop = 3'b010;
      v.src = 1; v.wds = 1; v.mem = 1;
    end else if (op == 7) begin
      v.n = 2 + dly; v.aop = 3'b010; v.src = 1;
      v.mem = 1; v.we = 1;
    end else if (op == 8 || op == 9) begin
      v.n = 2; v.aop = 3'b110;
      v.bt = (op == 8) ? z : !z;
    end else begin
      v.n = 1; v.ill = 1;
    end
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(instr_ready), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rr1"}, 32'(rr1), 0);
    chk({tag, "_aop"}, 32'(alu_op), 0);
    chk({tag, "_imm"}, 32'(imm), 0);
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run(input vec_t v);
    bit inmem;
    instr = v.instr;
    instr_valid = 1'b1;
    zero = v.z;
    mem_ack = 1'b0;
    @(negedge clock);
    chk("accept_ready", 32'(instr_ready), 1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    for (int i = 1; i <= v.n; i++) begin
      if (v.mem && i > 2) mem_ack = (i == 2 + v.dly);
      else mem_ack = 1'($urandom_range(0, 1));
      inmem = v.mem && i > 2 && i <= 2 + v.dly;
      @(negedge clock);
      chk("busy_ready", 32'(instr_ready), 0);
      chk("rr1", 32'(rr1), 32'(v.instr[11:10]));
      chk("rr2", 32'(rr2), 32'(v.instr[9:8]));
      chk("wr", 32'(wr), 32'(v.wr));
      chk("alu_op", 32'(alu_op), 32'(v.aop));
      chk("imm", 32'(imm), 32'(v.imm));
      chk("alu_src_imm", 32'(alu_src_imm), 32'(v.src));
      chk("wd_sel", 32'(wd_sel), 32'(v.wds));
      chk("done", 32'(done), 32'(i == v.n));
      chk("regwrite", 32'(regwrite), 32'(v.rw && i == v.n));
      chk("illegal", 32'(illegal), 32'(v.ill && i == v.n));
      chk("branch_taken", 32'(branch_taken),
          32'(v.bt && i == v.n));
      chk("mem_req", 32'(mem_req), 32'(inmem));
      chk("mem_we", 32'(mem_we), 32'(inmem && v.we));
      @(posedge clock); #1;
    end
    mem_ack = 1'b0;
    @(negedge clock);
    chk_idle("after");
    @(posedge clock); #1;
  endtask

  vec_t tbl[9];

  initial begin
    reset_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    zero = 1'b0;
    mem_ack = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset_regwrite", 32'(regwrite), 0);
    chk("reset_mem_req", 32'(mem_req), 0);
    chk("reset_wr", 32'(wr), 0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    //          instr     z  dly n rw wr aop     imm       src wds ill bt mem we
    tbl[0] = '{16'h1240, 0, 1, 3, 1, 1, 3'b110, 16'h0040, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{16'h5CFF, 0, 1, 3, 0, 0, 3'b010, 16'hFFFF, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{16'h6305, 0, 3, 6, 1, 3, 3'b010, 16'h0005, 1, 1, 0, 0, 1, 0};
    tbl[3] = '{16'h8500, 1, 1, 2, 0, 1, 3'b110, 16'h0000, 0, 0, 0, 1, 0, 0};
    tbl[4] = '{16'h9500, 1, 1, 2, 0, 1, 3'b110, 16'h0000, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{16'hF000, 0, 1, 1, 0, 0, 3'b000, 16'h0000, 0, 0, 1, 0, 0, 0};
    tbl[6] = '{16'h7200, 0, 1, 3, 0, 2, 3'b010, 16'h0000, 1, 0, 0, 0, 1, 1};
    tbl[7] = '{16'h4B3C, 0, 1, 3, 0, 0, 3'b111, 16'h003C, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{16'h0E80, 0, 1, 3, 1, 2, 3'b010, 16'hFF80, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 9; k++) run(tbl[k]);

    // Valid held through a busy period; second instr taken at T+4.
    instr = 16'h2640;
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr = 16'h3A80;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      chk("held_busy_ready", 32'(instr_ready), 0);
      chk("held_rr1", 32'(rr1), 1);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("held_ready_t4", 32'(instr_ready), 1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(negedge clock);
    chk("held_second_rr1", 32'(rr1), 2);
    chk("held_second_aop", 32'(alu_op), 32'(3'b001));
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    chk_idle("held_end");
    @(posedge clock); #1;

    // Reset during MEM of a store aborts it asynchronously.
    instr = 16'h7200;
    instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_pre_mem_req", 32'(mem_req), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_ready", 32'(instr_ready), 1);
    chk("abort_done", 32'(done), 0);
    @(posedge clock);
    chk("abort_edge_done", 32'(done), 0);
    #1 reset_n = 1'b1;
    run(tbl[0]);

    for (int k = 0; k < 60; k++)
      run(model(16'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4))));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the 16-bit datapath: accepts one instruction at a time over a valid/ready handshake and decodes it. It then steps the 4-entry register file (r0 reads zero, not writable), the 3-bit-op ALU and a data-memory port through decode, execute, memory and writeback cycles. It sits between the instruction source and the existing register file / ALU. It owns every regwrite, read/write select, ALU op and memory strobe.

## Interface
- Parameters: none. Widths are fixed at 16-bit data, 2-bit register index and 3-bit ALU op.
- One clock; reset is asynchronous and active-low.
- Ports, clock and reset first:
  - clock  in  1  rising-edge clock
  - reset_n  in  1  async active-low reset
  - instr  in  16  instruction: op[15:12], rs[11:10], rt[9:8], rd[7:6], imm8[7:0]
  - instr_valid  in  1  instr is presented
  - instr_ready  out  1  controller idle, accepts instr
  - zero  in  1  ALU zero flag
  - mem_ack  in  1  memory completed the request
  - rr1, rr2  out  2  register-file read selects
  - wr  out  2  register-file write select
  - regwrite  out  1  register-file write enable, one cycle
  - alu_op  out  3  {binvert, sel[1:0]}
  - alu_src_imm  out  1  ALU b operand = imm, not rd2
  - imm  out  16  sign-extended imm8
  - wd_sel  out  1  0 = ALU result, 1 = memory data
  - mem_req, mem_we  out  1  memory request / write strobe
  - branch_taken  out  1  one-cycle pulse; PC logic adds imm
  - done  out  1  one-cycle instruction-complete pulse
  - illegal  out  1  one-cycle pulse for an undefined opcode

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT. Form is rd ← rs op rt.
  - 5 ADDI: rt ← rs + imm.
  - 6 LW: rt ← mem[rs+imm].
  - 7 SW: mem[rs+imm] ← rt.
  - 8 BEQ, 9 BNE: compare rs, rt.
  - 10–15 are illegal.
- ALU op map: AND=000, OR=001, ADD=010, SUB=110, SLT=111. ADDI, LW and SW use 010. BEQ and BNE use 110.
- States: IDLE, DECODE, EXEC, MEM, WB.
- Transitions:
  - IDLE→DECODE on instr_valid & instr_ready. The instruction is latched into an internal register; instr is not sampled afterward.
  - DECODE→EXEC for a legal opcode. DECODE→IDLE for an illegal one, pulsing illegal and done.
  - EXEC→WB for R-type and ADDI.
  - EXEC→MEM for LW and SW.
  - EXEC→IDLE for branches. branch_taken = zero for BEQ, !zero for BNE. done pulses.
  - MEM holds mem_req (and mem_we for SW) until mem_ack. On mem_ack, LW goes →WB and SW goes →IDLE with done.
  - WB asserts regwrite for one cycle and →IDLE with done.
- Register selects:
  - rr1=rs, rr2=rt, driven from DECODE through WB.
  - wr=rd for R-type, wr=rt otherwise.
  - Destination 0: regwrite is suppressed, the WB cycle still occurs and done still pulses.
- imm = {{8{imm8[7]}}, imm8}. alu_src_imm=1 for ADDI, LW and SW. wd_sel=1 only for LW.

## Timing
- Reset values: state IDLE, instr_ready=1, and every other output 0, including rr1, rr2, wr, alu_op and imm.
- Reset asserted mid-instruction aborts it immediately. The aborted instruction produces no regwrite, mem_req, done or branch_taken.
- instr_ready=1 only in IDLE. The accept edge is cycle T.
- Latency counted from T (all are occupancy cycles):
  - R-type / ADDI: regwrite at T+3, done at T+3, instr_ready again at T+4.
  - Branch: branch_taken and done at T+2.
  - LW with mem_ack first seen in cycle M: regwrite and done at M+1.
  - SW: done in the mem_ack cycle.
  - Illegal: illegal and done at T+1.
- Control outputs are registered or decoded from the state plus the latched instruction. They are stable for the whole state and do not combinationally depend on instr_valid.
- mem_ack outside MEM is ignored. An ack in the same cycle MEM is entered is honoured.
- A new instruction held valid during a busy period is accepted on the first IDLE cycle.

## Structure
- Shared package holds:
  - opcode constants (OP_ADD … OP_BNE);
  - ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT);
  - the state enum.
- One natural sub-module, control_decode: a combinational map from the latched opcode to alu_op, alu_src_imm, wd_sel, dest-select, class (R / I / load / store / branch / illegal).
- The FSM and instruction register stay in the top.

## Test plan
- Reset then SUB: instr=0x1240 (SUB rd=1, rs=0, rt=2) accepted at T. Required: rr1=0, rr2=2, alu_op=110; regwrite with wr=1 at T+3; done at T+3; instr_ready at T+4.
- ADDI to r0: instr=0x5CFF. Required: imm=0xFFFF, alu_src_imm=1; regwrite never high; done at T+3.
- LW with 3-cycle ack delay: instr=0x6305. Required:
  - mem_req high, mem_we=0, for 3 cycles;
  - regwrite with wr=3 and wd_sel=1 the cycle after mem_ack;
  - imm=0x0005.
- BEQ/BNE: 0x8500 with zero=1 gives branch_taken at T+2. 0x9500 with zero=1 gives no branch_taken, and done still pulses at T+2.
- Illegal 0xF000: illegal and done at T+1; no regwrite or mem_req.
- reset_n low during MEM of SW 0x7200: mem_req drops asynchronously, instr_ready=1, no done. The next instruction executes normally.
